// File: rtl/rv32i_lsu.sv
// Load/store unit: one memory op at a time onto a word-addressed RAM bus with
// byte enables; returns lane-aligned, extended load data or an error pulse.
module rv32i_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_ram_mask,
    input  logic [2:0]  req_reg_mask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          op_q;
    logic [1:0]    lane_q;
    logic [2:0]    rmask_q;
    logic          mem_req_q, mem_we_q, resp_valid_q, resp_err_q;
    logic [31:0]   mem_addr_q, mem_wdata_q, resp_rdata_q;
    logic [3:0]    mem_be_q;

    size_e       sz_d;
    logic        illegal_d, misalign_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    // Request decode: access width, legality, byte lanes and replicated data
    always_comb begin
        sz_d      = SZ_W;
        illegal_d = 1'b0;
        if (req_op) begin
            case (req_ram_mask)
                2'd0:    sz_d = SZ_B;
                2'd1:    sz_d = SZ_H;
                2'd2:    sz_d = SZ_W;
                default: illegal_d = 1'b1;
            endcase
        end else begin
            case (req_reg_mask)
                3'd0, 3'd2: sz_d = SZ_B;
                3'd1, 3'd3: sz_d = SZ_H;
                3'd4:       sz_d = SZ_W;
                default:    illegal_d = 1'b1;
            endcase
        end
        misalign_d = ((sz_d == SZ_H) && req_addr[0]) ||
                     ((sz_d == SZ_W) && (req_addr[1:0] != 2'b00));
        case (sz_d)
            SZ_B:    begin be_d = 4'b0001 << req_addr[1:0]; wdata_d = {4{req_wdata[7:0]}};  end
            SZ_H:    begin be_d = 4'b0011 << req_addr[1:0]; wdata_d = {2{req_wdata[15:0]}}; end
            default: begin be_d = 4'b1111;                  wdata_d = req_wdata;            end
        endcase
    end

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  mask);
        logic [31:0] s;
        s = word >> {lane, 3'b000};
        case (mask)
            3'd0:    load_ext = {{24{s[7]}}, s[7:0]};
            3'd1:    load_ext = {{16{s[15]}}, s[15:0]};
            3'd2:    load_ext = {24'b0, s[7:0]};
            3'd3:    load_ext = {16'b0, s[15:0]};
            default: load_ext = s;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= 1'b0;
            lane_q       <= 2'b0;
            rmask_q      <= 3'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    if (req_valid) begin
                        op_q    <= req_op;
                        lane_q  <= req_addr[1:0];
                        rmask_q <= req_reg_mask;
                        if (illegal_d || misalign_d) begin
                            // Rejected before touching the bus
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_BUS;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_op;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ack) begin
                        // Ack beats a simultaneous timeout expiry
                        state_q      <= S_RESP;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= op_q ? 32'b0 : load_ext(mem_rdata, lane_q, rmask_q);
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        state_q      <= S_RESP;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: directed and random ops on a default-timeout instance and
// a TIMEOUT_CYCLES=4 instance, checked against an arithmetic reference model.
module tb_rv32i_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1, a0, a1, op;
    logic [31:0] addr, wd, rd;
    logic [1:0]  rm;
    logic [2:0]  gm;

    logic        rdy0, rv0, re0, mq0, we0, rdy1, rv1, re1, mq1, we1;
    logic [31:0] rdat0, ma0, mw0, rdat1, ma1, mw1;
    logic [3:0]  be0, be1;

    logic        sel;
    logic        s_rdy, s_rv, s_re, s_mq, s_we;
    logic [31:0] s_rdat, s_ma, s_mw;
    logic [3:0]  s_be;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign s_rdy  = sel ? rdy1  : rdy0;
    assign s_rv   = sel ? rv1   : rv0;
    assign s_re   = sel ? re1   : re0;
    assign s_mq   = sel ? mq1   : mq0;
    assign s_we   = sel ? we1   : we0;
    assign s_rdat = sel ? rdat1 : rdat0;
    assign s_ma   = sel ? ma1   : ma0;
    assign s_mw   = sel ? mw1   : mw0;
    assign s_be   = sel ? be1   : be0;

    rv32i_lsu dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_op(op),
        .req_addr(addr), .req_wdata(wd), .req_ram_mask(rm), .req_reg_mask(gm),
        .resp_valid(rv0), .resp_rdata(rdat0), .resp_err(re0), .mem_req(mq0),
        .mem_we(we0), .mem_addr(ma0), .mem_be(be0), .mem_wdata(mw0),
        .mem_ack(a0), .mem_rdata(rd)
    );

    rv32i_lsu #(.TIMEOUT_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_op(op),
        .req_addr(addr), .req_wdata(wd), .req_ram_mask(rm), .req_reg_mask(gm),
        .resp_valid(rv1), .resp_rdata(rdat1), .resp_err(re1), .mem_req(mq1),
        .mem_we(we1), .mem_addr(ma1), .mem_be(be1), .mem_wdata(mw1),
        .mem_ack(a1), .mem_rdata(rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: width in bytes, lane offset, replication and extension by arithmetic
    function automatic void model(input logic o, input logic [31:0] ad, input logic [31:0] w,
                                  input logic [31:0] r, input logic [1:0] m_r,
                                  input logic [2:0] m_g, output logic err,
                                  output logic [3:0] be, output logic [31:0] mwd,
                                  output logic [31:0] rdat);
        int nb, off, t;
        logic ill, sgn;
        logic [63:0] msk, v;
        nb  = 4;
        ill = 1'b0;
        if (o) begin
            if (m_r == 2'd0) nb = 1;
            else if (m_r == 2'd1) nb = 2;
            else if (m_r == 2'd2) nb = 4;
            else ill = 1'b1;
        end else begin
            if (m_g == 3'd0 || m_g == 3'd2) nb = 1;
            else if (m_g == 3'd1 || m_g == 3'd3) nb = 2;
            else if (m_g == 3'd4) nb = 4;
            else ill = 1'b1;
        end
        off = int'(ad % 4);
        err = ill || ((int'(ad % 4) % nb) != 0);
        t   = ((1 << nb) - 1) << off;
        be  = t[3:0];
        for (int i = 0; i < 4; i++) mwd[8*i +: 8] = w[8*(i % nb) +: 8];
        sgn = !o && (m_g == 3'd0 || m_g == 3'd1);
        msk = (64'd1 << (8 * nb)) - 64'd1;
        v   = ({32'b0, r} >> (8 * off)) & msk;
        if (sgn && v[8*nb-1]) v = v | ~msk;
        rdat = o ? 32'b0 : v[31:0];
    endfunction

    // k = BUS cycle carrying the ack (0 = never ack)
    task automatic run_op(input logic s, input logic o, input logic [31:0] ad,
                          input logic [31:0] w, input logic [31:0] r,
                          input logic [1:0] m_r, input logic [2:0] m_g, input int k);
        logic e;
        logic [3:0] ebe;
        logic [31:0] ewd, erd;
        int tmax, ncyc;
        bit to;
        model(o, ad, w, r, m_r, m_g, e, ebe, ewd, erd);
        sel = s; op = o; addr = ad; wd = w; rm = m_r; gm = m_g; rd = $urandom;
        #1;
        chk("ready_idle", 32'(s_rdy), 32'd1);
        if (s) v1 = 1'b1; else v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        op = 1'($urandom); addr = $urandom; wd = $urandom; rm = 2'($urandom); gm = 3'($urandom);
        if (e) begin
            chk("err_valid", 32'(s_rv), 32'd1);
            chk("err_flag", 32'(s_re), 32'd1);
            chk("err_rdata", s_rdat, 32'd0);
            chk("err_no_mreq", 32'(s_mq), 32'd0);
            chk("err_not_ready", 32'(s_rdy), 32'd0);
            @(posedge clk); #1;
            chk("err_ready_again", 32'(s_rdy), 32'd1);
            chk("err_valid_pulse", 32'(s_rv), 32'd0);
            chk("err_no_mreq2", 32'(s_mq), 32'd0);
            return;
        end
        tmax = s ? 4 : 255;
        to   = (k == 0) || (k > tmax);
        ncyc = to ? tmax : k;
        for (int c = 1; c <= ncyc; c++) begin
            chk("bus_mreq", 32'(s_mq), 32'd1);
            chk("bus_we", 32'(s_we), 32'(o));
            chk("bus_addr", s_ma, {ad[31:2], 2'b00});
            chk("bus_be", 32'(s_be), 32'(ebe));
            if (o) chk("bus_wdata", s_mw, ewd);
            chk("bus_no_resp", 32'(s_rv), 32'd0);
            chk("bus_not_ready", 32'(s_rdy), 32'd0);
            if (!to && c == ncyc) begin
                rd = r;
                if (s) a1 = 1'b1; else a0 = 1'b1;
            end
            @(posedge clk); #1;
            a0 = 1'b0; a1 = 1'b0; rd = $urandom;
        end
        chk("resp_valid", 32'(s_rv), 32'd1);
        chk("resp_err", 32'(s_re), 32'(to));
        chk("resp_rdata", s_rdat, to ? 32'd0 : erd);
        chk("resp_mreq_low", 32'(s_mq), 32'd0);
        chk("resp_not_ready", 32'(s_rdy), 32'd0);
        @(posedge clk); #1;
        chk("post_ready", 32'(s_rdy), 32'd1);
        chk("post_valid_low", 32'(s_rv), 32'd0);
    endtask

    initial begin
        reset = 1'b1; v0 = 1'b0; v1 = 1'b0; a0 = 1'b0; a1 = 1'b0; sel = 1'b0;
        op = 1'b0; addr = '0; wd = '0; rd = '0; rm = '0; gm = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #1;
            chk("rst_ready", 32'(s_rdy), 32'd1);
            chk("rst_valid", 32'(s_rv), 32'd0);
            chk("rst_err", 32'(s_re), 32'd0);
            chk("rst_mreq", 32'(s_mq), 32'd0);
            chk("rst_we", 32'(s_we), 32'd0);
            chk("rst_addr", s_ma, 32'd0);
            chk("rst_be", 32'(s_be), 32'd0);
            chk("rst_wdata", s_mw, 32'd0);
            chk("rst_rdata", s_rdat, 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(0, 1, 32'h0000_1003, 32'h1234_56AB, 32'h0, 2'd0, 3'd0, 1);   // SB lane 3
        run_op(0, 0, 32'h0000_2001, 32'h0, 32'h0000_F000, 2'd0, 3'd0, 1);   // LB
        run_op(0, 0, 32'h0000_2001, 32'h0, 32'h0000_F000, 2'd0, 3'd2, 1);   // LBU
        run_op(0, 0, 32'h0000_2002, 32'h0, 32'h8000_0000, 2'd0, 3'd1, 1);   // LH
        run_op(0, 0, 32'h0000_2002, 32'h0, 32'h8000_0000, 2'd0, 3'd3, 2);   // LHU
        run_op(0, 0, 32'h0000_3002, 32'h0, 32'h0, 2'd0, 3'd4, 1);           // LW misaligned
        run_op(0, 1, 32'h0000_3001, 32'h5555_5555, 32'h0, 2'd1, 3'd0, 1);   // SH misaligned
        run_op(0, 1, 32'h0000_3000, 32'h5555_5555, 32'h0, 2'd3, 3'd0, 1);   // illegal store mask
        run_op(0, 0, 32'h0000_3000, 32'h0, 32'h0, 2'd0, 3'd5, 1);           // illegal load mask
        run_op(0, 0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 2'd0, 3'd4, 5);   // wait states
        run_op(0, 1, 32'h0000_4002, 32'hCAFE_BABE, 32'h0, 2'd1, 3'd0, 3);   // SH upper half
        run_op(1, 0, 32'h0000_5000, 32'h0, 32'h1111_2222, 2'd0, 3'd4, 0);   // timeout, no ack
        run_op(1, 0, 32'h0000_5004, 32'h0, 32'h8765_4321, 2'd0, 3'd4, 4);   // ack on expiry cycle
        run_op(1, 1, 32'h0000_5008, 32'hA5A5_0F0F, 32'h0, 2'd2, 3'd0, 0);   // store timeout

        // Stray ack while idle must not produce a response
        sel = 1'b0; a0 = 1'b1;
        @(posedge clk); #1;
        a0 = 1'b0;
        chk("stray_ack_valid", 32'(s_rv), 32'd0);
        chk("stray_ack_ready", 32'(s_rdy), 32'd1);

        // Reset while a load waits on the bus
        sel = 1'b0; op = 1'b0; addr = 32'h0000_6000; gm = 3'd4; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        chk("rstbus_mreq", 32'(s_mq), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rstbus_mreq_async", 32'(s_mq), 32'd0);
        chk("rstbus_no_resp", 32'(s_rv), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstbus_ready", 32'(s_rdy), 32'd1);
        @(posedge clk); #1;
        chk("rstbus_no_resp2", 32'(s_rv), 32'd0);
        run_op(0, 0, 32'h0000_6003, 32'h0, 32'h7F00_0000, 2'd0, 3'd0, 1);

        // Random traffic on both instances
        for (int i = 0; i < 40; i++)
            run_op(0, 1'($urandom), $urandom, $urandom, $urandom, 2'($urandom),
                   3'($urandom_range(0, 5)), $urandom_range(1, 4));
        for (int i = 0; i < 20; i++)
            run_op(1, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                   2'($urandom_range(0, 2)), 3'($urandom_range(0, 4)), $urandom_range(0, 6));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit for the rv32i core. It sits directly downstream of decode/execute. It accepts one memory operation, described by `mem_op_e`, `ram_mask_e` and `reg_mask_e` plus the ALU-computed address. It drives a word-addressed single-port RAM bus with byte enables, then returns lane-aligned and extended load data for the `WB_MEM` writeback path. Misaligned accesses and bus timeouts are reported as errors without corrupting memory.

## Interface
Clock is `clk`. Reset is `reset`: asynchronous, active-high.

Parameters:
- `TIMEOUT_CYCLES`, default 255: number of cycles without `mem_ack` before a bus error is raised. 0 disables the timeout.

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  operation offered
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_op`  in  1  `mem_op_e`: MEM_LOAD=0, MEM_STORE=1
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data (rs2)
- `req_ram_mask`  in  2  `ram_mask_e` store width: B=0, H=1, W=2
- `req_reg_mask`  in  3  `reg_mask_e` load width/extension: B=0 (sign), H=1 (sign), BX=2 (zero), HX=3 (zero), W=4
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_err`  out  1  misaligned, illegal mask, or timeout; valid with `resp_valid`
- `mem_req`  out  1  bus request, held until ack or timeout
- `mem_we`  out  1  1 for store
- `mem_addr`  out  32  `{req_addr[31:2], 2'b00}`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_ack`  in  1  bus completion; load data valid on `mem_rdata` in the same cycle
- `mem_rdata`  in  32  read word

## Operation
- **Effective width:**
  - Stores use `req_ram_mask`.
  - Loads use `req_reg_mask`: B/BX give byte, H/HX give half, W gives word.
- **Handshake:** a request is accepted on a rising edge where `req_valid & req_ready`. All request fields are registered at that edge.
- **States:**
  - IDLE: `req_ready`=1.
    - Accepted, legal → BUS.
    - Accepted, misaligned or illegal mask → RESP with err=1.
  - BUS: `mem_req`=1, `mem_addr`/`mem_be`/`mem_we`/`mem_wdata` stable.
    - `mem_ack`=1 → RESP; `mem_rdata` is captured.
    - Timeout → RESP with err=1.
  - RESP: `resp_valid`=1 for one cycle → IDLE.
- **Misaligned access:**
  - Half with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
- **Illegal mask:** `req_ram_mask`=3 on a store, or `req_reg_mask`≥5 on a load.
- **Byte enables:**
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << addr[1:0]`.
  - W: `4'b1111`.
  - Loads drive the same `mem_be`.
- **Store data:**
  - B: `{4{wdata[7:0]}}`.
  - H: `{2{wdata[15:0]}}`.
  - W: `wdata`.
- **Load data:**
  - The addressed lane is `mem_rdata >> (8*addr[1:0])`.
  - B/H are sign-extended from bit 7/15; BX/HX are zero-extended; W is passed through.
- **Timeout:**
  - The counter clears on entry to BUS and increments on each BUS cycle without ack.
  - When `TIMEOUT_CYCLES` cycles have elapsed without ack, the unit leaves BUS.
  - `mem_ack` in the same cycle as expiry wins: normal completion, err=0.
- `mem_ack` while not in BUS is ignored.

## Timing
- **Reset values:**
  - State is IDLE.
  - `mem_req`, `mem_we`, `resp_valid`, `resp_err` are 0.
  - `mem_addr`, `mem_be`, `mem_wdata`, `resp_rdata` are 0.
  - `req_ready`=1 (IDLE).
- **Reset mid-operation:**
  - `mem_req` drops asynchronously.
  - No response is produced.
  - An in-flight bus write is the bus owner's concern.
- **Legal access, acceptance at edge N:**
  - `mem_req` is high from cycle N+1.
  - With ack in cycle N+k, `resp_valid` is high in cycle N+k+1.
  - `req_ready` is high again in cycle N+k+2.
  - Minimum request-to-response is 2 cycles.
- **Misaligned/illegal access:**
  - `resp_valid`/`resp_err` are high in cycle N+1.
  - `mem_req` is never asserted.
- **Timeout:** with `TIMEOUT_CYCLES`=T, `mem_req` is high for T cycles (N+1..N+T) and the response comes in cycle N+T+1.
- **Throughput:** one operation in flight; back-to-back requests are separated by the RESP cycle.

## Test plan
- **SB lane replication:** SB, addr 0x1003, wdata 0x123456AB, ack on first BUS cycle → `mem_addr`=0x1000, `mem_be`=4'b1000, `mem_wdata`=0xABABABAB, `mem_we`=1; `resp_valid` 2 cycles after accept; err=0, rdata=0.
- **Load extension:** LB/LBU at addr 0x2001 with `mem_rdata`=0x0000F000 → rdata 0xFFFFFFF0 / 0x000000F0; LH at 0x2002 with `mem_rdata`=0x80000000 → rdata 0xFFFF8000.
- **Misaligned/illegal:**
  - LW at 0x3002 → no `mem_req`; `resp_valid`=1 and err=1 in cycle N+1.
  - SH at 0x3001 → same.
  - Store with `req_ram_mask`=3 → err=1, no bus access.
- **Wait states:** ack after 5 BUS cycles, LW 0x4000, `mem_rdata`=0xDEADBEEF → `mem_req` held 5 cycles with stable outputs; rdata 0xDEADBEEF in cycle N+6.
- **Timeout:**
  - `TIMEOUT_CYCLES`=4, no ack → `mem_req` high exactly 4 cycles; err=1, rdata=0 in cycle N+5.
  - Ack in the 4th cycle → normal completion, err=0.
- **Reset in BUS:** assert `reset` while in BUS → `mem_req` low asynchronously, no `resp_valid`; `req_ready`=1 after release, and the next request completes normally.
